fetch_ctrl: RTL and testbench

//  Sequences the byte-addressed, registered-read instruction memory (im). Owns the PC,

---
 rtl/fetch_ctrl.sv | 81 ++++++++
 tb/tb_fetch_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC owner and fetch sequencer between a registered-read instruction memory and decode
module fetch_ctrl #(
  parameter int                 ADDR_W     = 32,
  parameter int                 IMEM_BYTES = 64,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_pc,
  input  logic [31:0]       imem_inst,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_inst,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted,
  output logic              fetch_err
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;
  logic [1:0]        state;
  logic [ADDR_W-1:0] pc_q, req_pc_q;
  logic              inflight;
  logic              free, in_range, run, adv, drain;
  // widened compare so a PC near the top of the address space cannot wrap into range
  assign in_range = ({1'b0, pc_q} + (ADDR_W+1)'(3)) < (ADDR_W+1)'(IMEM_BYTES);
  assign free     = !if_valid || if_ready;
  assign run      = (state == FETCH) && !redirect && free;
  assign adv      = run && in_range;
  assign drain    = run && !in_range;
  // while stalled the memory re-reads the in-flight address so its output stays put
  assign imem_pc  = adv ? pc_q : req_pc_q;
  // redirect beats stall/advance; otherwise advance, drain into HALT, or hold
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc_q      <= RESET_PC;
      req_pc_q  <= '0;
      inflight  <= 1'b0;
      if_valid  <= 1'b0;
      if_inst   <= '0;
      if_pc     <= '0;
      halted    <= 1'b0;
      fetch_err <= 1'b0;
    end else if (redirect && state != IDLE) begin
      inflight <= 1'b0;
      if_valid <= 1'b0;
      if (redirect_pc[1:0] == 2'b00) begin
        pc_q   <= redirect_pc;
        state  <= FETCH;
        halted <= 1'b0;
      end else begin
        fetch_err <= 1'b1;
        state     <= HALT;
        halted    <= 1'b1;
      end
    end else if (state == IDLE) begin
      if (redirect) pc_q <= redirect_pc;
      if (start) state <= FETCH;
    end else if (adv || drain) begin
      if_valid <= inflight;
      inflight <= adv;
      if (inflight) begin
        if_inst <= imem_inst;
        if_pc   <= req_pc_q;
      end
      if (adv) begin
        req_pc_q <= pc_q;
        pc_q     <= pc_q + ADDR_W'(4);
      end else begin
        state  <= HALT;
        halted <= 1'b1;
      end
    end else if (state == HALT && if_valid && if_ready) begin
      if_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus random traffic checked against a queue-based fetch model
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1, start = 1'b0, if_ready = 1'b1, redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_pc, imem_inst, if_inst, if_pc;
  logic        if_valid, halted, fetch_err;
  int          n_vec = 0, n_err = 0;
  logic [7:0]  mem [64];
  bit          chk_en = 1'b0;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .imem_pc(imem_pc), .imem_inst(imem_inst),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a > 32'd60) return 32'h0;
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  // instruction memory with a registered read
  always @(posedge clk) imem_inst <= word(imem_pc);

  // model: mode, next PC, queue of addresses whose read is in flight, one output slot
  int          m_mode = 0;
  logic [31:0] m_pc = '0, m_opc = '0;
  logic [31:0] m_q [$];
  bit          m_ov = 0, m_halt = 0, m_err = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_pc = '0; m_q.delete(); m_ov = 0; m_halt = 0; m_err = 0;
    end else if (redirect && m_mode != 0) begin
      m_q.delete(); m_ov = 0;
      if (redirect_pc % 4 == 0) begin
        m_pc = redirect_pc; m_mode = 1; m_halt = 0;
      end else begin
        m_err = 1; m_mode = 2; m_halt = 1;
      end
    end else if (m_mode == 0) begin
      if (redirect) m_pc = redirect_pc;
      if (start) m_mode = 1;
    end else if (m_mode == 1) begin
      if (!m_ov || if_ready) begin
        m_ov = (m_q.size() > 0);
        if (m_ov) m_opc = m_q.pop_front();
        if (longint'(m_pc) + 3 < 64) begin
          m_q.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end else begin
          m_mode = 2; m_halt = 1;
        end
      end
    end else if (m_ov && if_ready) begin
      m_ov = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) if (chk_en) begin
    chk("valid", {31'b0, if_valid}, {31'b0, m_ov});
    chk("halted", {31'b0, halted}, {31'b0, m_halt});
    chk("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
    if (m_ov && if_valid) begin
      chk("if_pc", if_pc, m_opc);
      chk("if_inst", if_inst, word(m_opc));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    bit found;
    foreach (mem[i]) mem[i] = 8'($urandom);
    {mem[0], mem[1], mem[2], mem[3]} = 32'h0A0A2A0A;
    step(); step();
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_inst", if_inst, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    rst = 1'b0; chk_en = 1'b1;
    // stream from reset PC
    start = 1'b1; step(); start = 1'b0;
    step(); chk("first_lat", {31'b0, if_valid}, 32'd0);
    step(); chk("first_valid", {31'b0, if_valid}, 32'd1);
    chk("first_pc", if_pc, 32'd0);
    chk("first_inst", if_inst, 32'h0A0A2A0A);
    step(); chk("pc4", if_pc, 32'd4);
    step(); chk("pc8", if_pc, 32'd8);
    // stall three cycles on pc 8
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin step(); chk("stall_pc", if_pc, 32'd8); end
    if_ready = 1'b1;
    step(); chk("resume_pc", if_pc, 32'd12);
    step(); chk("pc16", if_pc, 32'd16);
    // redirect flushes the word in flight
    redirect = 1'b1; redirect_pc = 32'd20; step(); redirect = 1'b0;
    chk("flush_valid", {31'b0, if_valid}, 32'd0);
    step(); chk("redir_lat", {31'b0, if_valid}, 32'd0);
    step(); chk("redir_pc", if_pc, 32'd20);
    step(); chk("redir_pc2", if_pc, 32'd24);
    // run off the end of memory
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(); found = if_valid && if_pc == 32'd60;
    end
    chk("reach_60", {31'b0, found}, 32'd1);
    chk("end_halted", {31'b0, halted}, 32'd1);
    step(); chk("end_drop", {31'b0, if_valid}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'd0; step(); redirect = 1'b0;
    chk("unhalt", {31'b0, halted}, 32'd0);
    step(); step(); chk("restart_pc", if_pc, 32'd0);
    chk("restart_valid", {31'b0, if_valid}, 32'd1);
    // misaligned redirect
    redirect = 1'b1; redirect_pc = 32'd6; step(); redirect = 1'b0;
    chk("mis_err", {31'b0, fetch_err}, 32'd1);
    chk("mis_halt", {31'b0, halted}, 32'd1);
    redirect = 1'b1; redirect_pc = 32'd8; step(); redirect = 1'b0;
    chk("err_sticky", {31'b0, fetch_err}, 32'd1);
    if_ready = 1'b0; step(); step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst2_valid", {31'b0, if_valid}, 32'd0);
    chk("rst2_err", {31'b0, fetch_err}, 32'd0);
    chk("rst2_pc", if_pc, 32'd0);
    chk("rst2_inst", if_inst, 32'd0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if_ready = ($urandom_range(3) != 0);
      start = ($urandom_range(19) == 0);
      redirect = ($urandom_range(29) == 0);
      redirect_pc = ($urandom_range(9) == 0) ? 32'($urandom_range(70))
                                            : 32'($urandom_range(18)) * 32'd4;
      rst = ($urandom_range(299) == 0);
      step();
    end
    rst = 1'b0; redirect = 1'b0; start = 1'b0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
